// File: rtl/board_cursor_ctrl.sv
// rtl/board_cursor_ctrl.sv - grid cursor navigation with cell-selection handshake
module board_cursor_ctrl #(
  parameter int ROWS  = 3,
  parameter int COLS  = 3,
  parameter int IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 key_up,
  input  logic                 key_down,
  input  logic                 key_left,
  input  logic                 key_right,
  input  logic                 key_select,
  input  logic [ROWS*COLS-1:0] occupied,
  input  logic                 sel_ready,
  output logic [IDX_W-1:0]     cursor,
  output logic [2:0]           cursor_row,
  output logic [2:0]           cursor_col,
  output logic                 player,
  output logic                 sel_valid,
  output logic [IDX_W-1:0]     sel_index,
  output logic                 sel_player,
  output logic                 reject
);

  localparam logic [2:0] ROW_MAX = 3'(ROWS - 1);
  localparam logic [2:0] COL_MAX = 3'(COLS - 1);

  // Bit positions inside the key vectors
  localparam int K_UP    = 0;
  localparam int K_DOWN  = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;
  localparam int K_SEL   = 4;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    NAV      = 2'd1,
    COMMIT   = 2'd2
  } state_t;

  state_t               state;
  logic [4:0]           key_now;
  logic [4:0]           key_prev;
  logic [4:0]           key_edge;
  logic [2:0]           row_inc;
  logic [2:0]           row_dec;
  logic [2:0]           col_inc;
  logic [2:0]           col_dec;
  logic [ROWS*COLS-1:0] occ_shift;
  logic                 cur_occupied;

  // Linear cell index from coordinates; always computed alongside the
  // coordinates so cursor never disagrees with cursor_row/cursor_col.
  function automatic logic [IDX_W-1:0] to_index(input logic [2:0] r,
                                                input logic [2:0] c);
    int lin;
    lin = int'(r) * COLS + int'(c);
    return lin[IDX_W-1:0];
  endfunction

  assign key_now  = {key_select, key_right, key_left, key_down, key_up};
  assign key_edge = key_now & ~key_prev;

  // Wrapping neighbours of the current cell
  assign row_inc = (cursor_row == ROW_MAX) ? 3'd0    : cursor_row + 3'd1;
  assign row_dec = (cursor_row == 3'd0)    ? ROW_MAX : cursor_row - 3'd1;
  assign col_inc = (cursor_col == COL_MAX) ? 3'd0    : cursor_col + 3'd1;
  assign col_dec = (cursor_col == 3'd0)    ? COL_MAX : cursor_col - 3'd1;

  // Occupancy of the cell under the cursor
  assign occ_shift    = occupied >> cursor;
  assign cur_occupied = occ_shift[0];

  // Previous key levels; updated every cycle so edges seen while disabled
  // or committing are consumed rather than replayed later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_prev <= '0;
    end else begin
      key_prev <= key_now;
    end
  end

  // Navigation / selection state machine with registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= DISABLED;
      cursor     <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      player     <= 1'b0;
      sel_valid  <= 1'b0;
      sel_index  <= '0;
      sel_player <= 1'b0;
      reject     <= 1'b0;
    end else begin
      reject <= 1'b0;
      case (state)
        DISABLED: begin
          if (enable) begin
            state <= NAV;
          end
        end
        NAV: begin
          if (!enable) begin
            state <= DISABLED;
          end else if (key_edge[K_SEL]) begin
            if (cur_occupied) begin
              reject <= 1'b1;
            end else begin
              sel_valid  <= 1'b1;
              sel_index  <= cursor;
              sel_player <= player;
              state      <= COMMIT;
            end
          end else if (key_edge[K_RIGHT]) begin
            cursor_col <= col_inc;
            cursor     <= to_index(cursor_row, col_inc);
          end else if (key_edge[K_LEFT]) begin
            cursor_col <= col_dec;
            cursor     <= to_index(cursor_row, col_dec);
          end else if (key_edge[K_DOWN]) begin
            cursor_row <= row_inc;
            cursor     <= to_index(row_inc, cursor_col);
          end else if (key_edge[K_UP]) begin
            cursor_row <= row_dec;
            cursor     <= to_index(row_dec, cursor_col);
          end
        end
        COMMIT: begin
          // Only a transfer leaves COMMIT; enable is consulted only to pick
          // where to go afterwards.
          if (sel_ready) begin
            sel_valid <= 1'b0;
            player    <= ~player;
            state     <= enable ? NAV : DISABLED;
          end
        end
        default: begin
          state <= DISABLED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_board_cursor_ctrl.sv
// tb/tb_board_cursor_ctrl.sv - directed vector bench for board_cursor_ctrl
module tb_board_cursor_ctrl;

  logic clk;
  logic reset;

  // Default 3x3 instance
  logic       enable, key_up, key_down, key_left, key_right, key_select;
  logic [8:0] occupied;
  logic       sel_ready;
  logic [3:0] cursor, sel_index;
  logic [2:0] cursor_row, cursor_col;
  logic       player, sel_valid, sel_player, reject;

  // 4x5 instance
  logic        enable2, key_up2, key_down2, key_left2, key_right2, key_select2;
  logic [19:0] occupied2;
  logic        sel_ready2;
  logic [4:0]  cursor2, sel_index2;
  logic [2:0]  cursor_row2, cursor_col2;
  logic        player2, sel_valid2, sel_player2, reject2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en, up, dn, lf, rt, sl;
    logic [8:0] occ;
    logic       rdy;
    logic [3:0] cur;
    logic       pl, sv;
    logic [3:0] si;
    logic       sp, rj;
  } vec_t;

  vec_t vecs[$];

  board_cursor_ctrl dut (
    .clk(clk), .reset(reset), .enable(enable),
    .key_up(key_up), .key_down(key_down), .key_left(key_left),
    .key_right(key_right), .key_select(key_select),
    .occupied(occupied), .sel_ready(sel_ready),
    .cursor(cursor), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .player(player), .sel_valid(sel_valid), .sel_index(sel_index),
    .sel_player(sel_player), .reject(reject)
  );

  board_cursor_ctrl #(.ROWS(4), .COLS(5), .IDX_W(5)) dut2 (
    .clk(clk), .reset(reset), .enable(enable2),
    .key_up(key_up2), .key_down(key_down2), .key_left(key_left2),
    .key_right(key_right2), .key_select(key_select2),
    .occupied(occupied2), .sel_ready(sel_ready2),
    .cursor(cursor2), .cursor_row(cursor_row2), .cursor_col(cursor_col2),
    .player(player2), .sel_valid(sel_valid2), .sel_index(sel_index2),
    .sel_player(sel_player2), .reject(reject2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic en, up, dn, lf, rt, sl,
                              input logic [8:0] occ, input logic rdy,
                              input logic [3:0] cur, input logic pl, sv,
                              input logic [3:0] si, input logic sp, rj);
    vec_t v;
    v.en = en; v.up = up; v.dn = dn; v.lf = lf; v.rt = rt; v.sl = sl;
    v.occ = occ; v.rdy = rdy; v.cur = cur; v.pl = pl; v.sv = sv;
    v.si = si; v.sp = sp; v.rj = rj;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] pack_out();
    return {cursor, cursor_row, cursor_col, player, sel_valid, sel_index, sel_player, reject};
  endfunction

  initial begin
    logic [17:0] exp;
    logic [2:0]  er, ec;

    reset = 1'b1;
    enable = 1'b1; key_up = 0; key_down = 0; key_left = 0; key_right = 0; key_select = 0;
    occupied = '0; sel_ready = 0;
    enable2 = 1'b1; key_up2 = 0; key_down2 = 0; key_left2 = 0; key_right2 = 0; key_select2 = 0;
    occupied2 = '0; sel_ready2 = 0;

    //               en up dn lf rt sl  occ     rdy cur pl sv si sp rj
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  0, 0, 0, 0, 0, 0)); // enter NAV
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 9'h000, 0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 9'h000, 0,  2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 9'h000, 0,  0, 0, 0, 0, 0, 0)); // right wrap
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 9'h000, 0,  6, 0, 0, 0, 0, 0)); // up wrap
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  6, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 9'h000, 0,  3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 9'h000, 0,  4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 9'h000, 0,  3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  3, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 9'h000, 0,  5, 0, 0, 0, 0, 0)); // left wrap
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  5, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 9'h000, 0,  8, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  8, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 9'h000, 0,  2, 0, 0, 0, 0, 0)); // down wrap
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 9'h000, 0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 9'h000, 0,  4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 9'h010, 0,  4, 0, 0, 0, 0, 1)); // reject
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h010, 0,  4, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 9'h000, 0,  4, 0, 1, 4, 0, 0)); // select
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 9'h000, 0,  4, 0, 1, 4, 0, 0)); // moves ignored
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  4, 0, 1, 4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 9'h000, 0,  4, 0, 1, 4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  4, 0, 1, 4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 1,  4, 1, 0, 4, 0, 0)); // transfer
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  4, 1, 0, 4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 9'h000, 0,  4, 1, 1, 4, 1, 0)); // select beats right
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 1,  4, 0, 0, 4, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 9'h000, 0,  4, 0, 1, 4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  4, 0, 1, 4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 9'h000, 1,  4, 1, 0, 4, 0, 0)); // select at transfer ignored
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  4, 1, 0, 4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 1,  4, 1, 0, 4, 0, 0)); // idle sel_ready
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  4, 1, 0, 4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 9'h000, 0,  5, 1, 0, 4, 0, 0)); // right beats left
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  5, 1, 0, 4, 0, 0));
    vecs.push_back(mk(1, 0, 1, 1, 0, 0, 9'h000, 0,  4, 1, 0, 4, 0, 0)); // left beats down
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  4, 1, 0, 4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 9'h000, 0,  4, 1, 0, 4, 0, 0)); // disable
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 9'h000, 0,  4, 1, 0, 4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 9'h000, 0,  4, 1, 0, 4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  4, 1, 0, 4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 9'h000, 0,  5, 1, 0, 4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  5, 1, 0, 4, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 9'h000, 0,  5, 1, 1, 5, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 9'h000, 0,  5, 1, 1, 5, 1, 0)); // enable drop keeps selection
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 9'h000, 1,  5, 0, 0, 5, 1, 0)); // transfer to DISABLED
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 9'h000, 0,  5, 0, 0, 5, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  5, 0, 0, 5, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 9'h000, 0,  3, 0, 0, 5, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 9'h000, 0,  3, 0, 0, 5, 1, 0));

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(pack_out()), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      enable = vecs[i].en; key_up = vecs[i].up; key_down = vecs[i].dn;
      key_left = vecs[i].lf; key_right = vecs[i].rt; key_select = vecs[i].sl;
      occupied = vecs[i].occ; sel_ready = vecs[i].rdy;
      tick();
      er  = 3'(vecs[i].cur / 4'd3);
      ec  = 3'(vecs[i].cur % 4'd3);
      exp = {vecs[i].cur, er, ec, vecs[i].pl, vecs[i].sv, vecs[i].si, vecs[i].sp, vecs[i].rj};
      chk($sformatf("vec%0d", i), 32'(pack_out()), 32'(exp));
    end

    // Held right key: exactly one move from cursor 3
    key_right = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("held_right%0d", i), 32'(cursor), 32'd4);
    end
    key_right = 1'b0;
    tick();

    // Reset during COMMIT discards the selection
    key_select = 1'b1;
    tick();
    chk("commit_before_reset", 32'({sel_valid, sel_index, sel_player}), 32'({1'b1, 4'd4, 1'b0}));
    key_select = 1'b0;
    reset = 1'b1;
    #1;
    chk("async_reset", 32'(pack_out()), 32'd0);
    key_right = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("held_over_reset%0d", i), 32'(pack_out()), 32'd0);
    end
    key_right = 1'b0;
    tick();
    key_right = 1'b1;
    tick();
    chk("press_after_reset", 32'({cursor, cursor_row, cursor_col}), 32'({4'd1, 3'd0, 3'd1}));
    key_right = 1'b0;
    tick();

    // 4x5 board wrap checks
    key_up2 = 1'b1; tick(); key_up2 = 1'b0;
    chk("b45_up", 32'({cursor2, cursor_row2, cursor_col2}), 32'({5'd15, 3'd3, 3'd0}));
    tick();
    key_left2 = 1'b1; tick(); key_left2 = 1'b0;
    chk("b45_left", 32'({cursor2, cursor_row2, cursor_col2}), 32'({5'd19, 3'd3, 3'd4}));
    tick();
    key_right2 = 1'b1; tick(); key_right2 = 1'b0;
    chk("b45_right", 32'({cursor2, cursor_row2, cursor_col2}), 32'({5'd15, 3'd3, 3'd0}));
    tick();
    key_down2 = 1'b1; tick(); key_down2 = 1'b0;
    chk("b45_down", 32'({cursor2, cursor_row2, cursor_col2}), 32'({5'd0, 3'd0, 3'd0}));
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/board_cursor_ctrl.md
BOARD_CURSOR_CTRL -- requirements
Module: board_cursor_ctrl

Interface
REQ-001 Parameter ROWS, default 3, board row count; legal range 2..8.
REQ-002 Parameter COLS, default 3, board column count; legal range 2..8.
REQ-003 Parameter IDX_W, default 4, cell-index width; SHALL satisfy 2**IDX_W >= ROWS*COLS.
REQ-004 clk  in  1  clock; all state changes on the rising edge.
REQ-005 reset  in  1  reset; asynchronous, active-high.
REQ-006 enable  in  1  high = navigation allowed; low = block parks in DISABLED.
REQ-007 key_up, key_down, key_left, key_right  in  1 each  move requests; level inputs, already debounced and synchronous to clk.
REQ-008 key_select  in  1  confirm request; level input, already debounced and synchronous to clk.
REQ-009 occupied  in  ROWS*COLS  bit i high = cell i already taken.
REQ-010 sel_ready  in  1  consumer accepts the pending selection.
REQ-011 cursor  out  IDX_W  linear cursor index = row*COLS+col.
REQ-012 cursor_row, cursor_col  out  3 each  cursor coordinates.
REQ-013 player  out  1  side to move; 0 = X, 1 = O.
REQ-014 sel_valid  out  1  selection pending.
REQ-015 sel_index  out  IDX_W  index of the pending selection.
REQ-016 sel_player  out  1  player owning the pending selection.
REQ-017 reject  out  1  one-cycle pulse: select was attempted on an occupied cell.

Function
REQ-018 Each key SHALL be rising-edge detected against its own registered previous value; only edges act, and a held key SHALL produce exactly one action.
REQ-019 FSM states SHALL be DISABLED, NAV and COMMIT.
REQ-020 DISABLED -> NAV when enable=1; NAV -> DISABLED when enable=0; in DISABLED all key edges are ignored and the cursor holds.
REQ-021 In NAV, with exactly one action selected per cycle, priority SHALL be select > right > left > down > up; lower-priority edges in the same cycle are discarded.
REQ-022 key_right: col = (col==COLS-1) ? 0 : col+1; row unchanged.
REQ-023 key_left: col = (col==0) ? COLS-1 : col-1; row unchanged.
REQ-024 key_down: row = (row==ROWS-1) ? 0 : row+1; col unchanged.
REQ-025 key_up: row = (row==0) ? ROWS-1 : row-1; col unchanged.
REQ-026 cursor, cursor_row and cursor_col SHALL update on the clock edge after the key edge (1-cycle latency) and SHALL be mutually consistent in every cycle.
REQ-027 A select edge in NAV on a cell with occupied[cursor]=0 SHALL, on the next edge: latch sel_index=cursor and sel_player=player, set sel_valid=1, and enter COMMIT.
REQ-028 A select edge in NAV on a cell with occupied[cursor]=1 SHALL pulse reject high for exactly one cycle; the state, player and cursor are unchanged.
REQ-029 In COMMIT, sel_valid, sel_index and sel_player SHALL hold stable, and all move and select edges are ignored, until sel_ready=1.
REQ-030 A cycle in COMMIT with sel_ready=1 SHALL be the transfer: on the next edge sel_valid=0, player toggles, and the state returns to NAV (or to DISABLED if enable=0).
REQ-031 A select edge in the same cycle as the transfer SHALL be ignored.
REQ-032 enable falling in COMMIT SHALL NOT drop the pending selection; the state leaves COMMIT only via transfer.
REQ-033 sel_ready while sel_valid=0 has no effect.

Reset
REQ-034 On reset, asynchronously: cursor=0, cursor_row=0, cursor_col=0, player=0, sel_valid=0, sel_index=0, sel_player=0, reject=0, state=DISABLED, and all edge-detect registers=0.
REQ-035 A key held high across reset release SHALL NOT produce an action until it is released and pressed again.
REQ-036 Reset asserted in COMMIT SHALL discard the pending selection without a transfer.

Verification
REQ-037 Default parameters, enable=1, three key_right edges -> cursor 1, 2, then 0 (row 0); one key_up edge from row 0 -> cursor_row=2, cursor=6.
REQ-038 Cursor=4, occupied=0, key_select edge -> sel_valid=1, sel_index=4, sel_player=0; key_right edges ignored; sel_ready held 1 for one cycle -> sel_valid=0 next cycle, player=1.
REQ-039 occupied[4]=1, cursor=4, key_select edge -> reject high exactly one cycle; sel_valid stays 0; player unchanged.
REQ-040 key_select and key_right edges in the same cycle on a free cell -> selection taken at the old cursor; cursor does not move.
REQ-041 ROWS=4, COLS=5: from cursor 19, key_right -> cursor 15; key_down -> cursor 0.
REQ-042 key_right held high for 10 cycles -> exactly one move; reset pulse during COMMIT -> all outputs return to their reset values and no transfer occurs.
